// File: rtl/ctr_feistel_crypt.sv
`default_nettype none
// ============================================================================
// Module      : ctr_feistel_crypt
// Description : CTR-mode stream cipher core. The counter block (iv + ctr) is
//               enciphered by a ROUND-round pipelined Feistel network and the
//               resulting keystream is XORed with the input block. Encryption
//               and decryption are the same operation.
// Ports       : clk, reset_n (synchronous, active-high despite the name)
//               sbox_valid/sbox_out  - S-box load, entries from index 0
//               key_tvalid/key       - round-key load, K_0 first
//               tvalid/text_in/iv    - input block and initial counter
//               valid/text_out       - output block (text_in ^ keystream)
//               ready                - only with CTR_FEISTEL_READY_EN defined
// Options     : CTR_FEISTEL_READY_EN - exposes the internal ready flag
// Revision    : 1.0 - initial release
// ============================================================================
module ctr_feistel_crypt #(
    parameter int ROUND      = 5,
    parameter int KEY_SIZE   = 128,
    parameter int F_LAT      = 6,
    parameter int ENCR_LAT   = 31,
    parameter int SBOX_WIDTH = 8,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sbox_valid,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    input  logic                  key_tvalid,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] text_in,
    input  logic [DATA_WIDTH-1:0] iv,
`ifdef CTR_FEISTEL_READY_EN
    output logic                  ready,
`endif
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] text_out
);
    // KEY_SIZE must equal DATA_WIDTH/2, ENCR_LAT must equal ROUND*F_LAT+1
    // and F_LAT must be at least 3 (key mix, S-box, mix+swap).
    localparam int c_HALF   = DATA_WIDTH / 2;
    localparam int c_NBYTE  = c_HALF / SBOX_WIDTH;
    localparam int c_SBOX_N = 1 << SBOX_WIDTH;
    localparam int c_KW     = $clog2(ROUND + 1);
    localparam int c_DLY    = ENCR_LAT - 1;
    localparam logic [c_KW-1:0]       c_KEY_FULL = c_KW'(ROUND);
    localparam logic [c_KW-1:0]       c_KEY_ONE  = c_KW'(1);
    localparam logic [SBOX_WIDTH:0]   c_SB_ONE   = (SBOX_WIDTH + 1)'(1);
    localparam logic [DATA_WIDTH-1:0] c_CTR_ONE  = DATA_WIDTH'(1);

    // The port is called reset_n for compatibility, but it is active-high.
    logic rst;
    assign rst = reset_n;

    // ------------------------------------------------------------------------
    // S-box and round-key storage with load counters
    // ------------------------------------------------------------------------
    logic [SBOX_WIDTH-1:0] r_sbox [0:c_SBOX_N-1];
    logic [KEY_SIZE-1:0]   r_key  [0:ROUND-1];
    logic [SBOX_WIDTH:0]   r_sbox_cnt;   // MSB set = all entries loaded
    logic [c_KW-1:0]       r_key_cnt;
    logic                  w_sbox_wr;
    logic                  w_key_wr;
    logic                  w_ready;
    logic                  w_accept;

    assign w_sbox_wr = sbox_valid && !r_sbox_cnt[SBOX_WIDTH];
    assign w_key_wr  = key_tvalid && (r_key_cnt < c_KEY_FULL);
    assign w_ready   = r_sbox_cnt[SBOX_WIDTH] && (r_key_cnt == c_KEY_FULL);
    assign w_accept  = tvalid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sbox_cnt <= '0;
            r_key_cnt  <= '0;
        end else begin
            if (w_sbox_wr) r_sbox_cnt <= r_sbox_cnt + c_SB_ONE;
            if (w_key_wr)  r_key_cnt  <= r_key_cnt + c_KEY_ONE;
        end
    end

    // Table contents are not cleared by reset; the counters gate their use.
    always_ff @(posedge clk) begin
        if (!rst && w_sbox_wr) r_sbox[r_sbox_cnt[SBOX_WIDTH-1:0]] <= sbox_out;
        if (!rst && w_key_wr)  r_key[r_key_cnt] <= key;
    end

`ifdef CTR_FEISTEL_READY_EN
    assign ready = w_ready;
`endif

    // ------------------------------------------------------------------------
    // Stage 0: counter block and text capture
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_ctr;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_s0_text;
    logic                  r_s0_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr      <= '0;
            r_s0_valid <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) r_ctr <= r_ctr + c_CTR_ONE;
        end
        if (w_accept) begin
            r_x       <= iv + r_ctr;
            r_s0_text <= text_in;
        end
    end

    // ------------------------------------------------------------------------
    // Valid and text delay lines, matched to the ROUND*F_LAT network depth
    // ------------------------------------------------------------------------
    logic [c_DLY-1:0]      r_vd;
    logic [DATA_WIDTH-1:0] r_td [0:c_DLY-1];

    always_ff @(posedge clk) begin
        if (rst) r_vd <= '0;
        else     r_vd <= {r_vd[c_DLY-2:0], r_s0_valid};
        r_td[0] <= r_s0_text;
        for (int k = 1; k < c_DLY; k++) r_td[k] <= r_td[k-1];
    end

    // ------------------------------------------------------------------------
    // Feistel rounds. Each round: key mix (1), S-box (1), F_LAT-3 delay
    // stages on the substituted word, then linear mix + swap (1).
    // ------------------------------------------------------------------------
    logic [ROUND:0][DATA_WIDTH-1:0] w_blk;
    assign w_blk[0] = r_x;

    for (genvar gi = 0; gi < ROUND; gi++) begin : g_round
        logic [c_HALF-1:0]     r_t;
        logic [c_HALF-1:0]     w_sub;
        logic [c_HALF-1:0]     w_u;
        logic [c_HALF-1:0]     w_f;
        logic [c_HALF-1:0]     r_u  [0:F_LAT-3];
        logic [DATA_WIDTH-1:0] r_lr [0:F_LAT-2];
        logic [DATA_WIDTH-1:0] r_out;

        for (genvar gj = 0; gj < c_NBYTE; gj++) begin : g_byte
            assign w_sub[gj*SBOX_WIDTH +: SBOX_WIDTH] =
                r_sbox[r_t[gj*SBOX_WIDTH +: SBOX_WIDTH]];
        end

        assign w_u = r_u[F_LAT-3];
        // u ^ rotl(u,8) ^ rotl(u,32)
        assign w_f = w_u
                   ^ {w_u[c_HALF-9:0],  w_u[c_HALF-1:c_HALF-8]}
                   ^ {w_u[c_HALF-33:0], w_u[c_HALF-1:c_HALF-32]};

        always_ff @(posedge clk) begin
            r_t     <= w_blk[gi][c_HALF-1:0] ^ r_key[gi];
            r_lr[0] <= w_blk[gi];
            r_u[0]  <= w_sub;
            for (int k = 1; k < F_LAT - 2; k++) r_u[k]  <= r_u[k-1];
            for (int k = 1; k < F_LAT - 1; k++) r_lr[k] <= r_lr[k-1];
            // L' = R ; R' = L ^ F(R, K)
            r_out <= {r_lr[F_LAT-2][c_HALF-1:0],
                      r_lr[F_LAT-2][DATA_WIDTH-1:c_HALF] ^ w_f};
        end

        assign w_blk[gi+1] = r_out;
    end

    // ------------------------------------------------------------------------
    // Output register: zero when no block exits
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            text_out <= '0;
        end else begin
            valid    <= r_vd[c_DLY-1];
            text_out <= r_vd[c_DLY-1] ? (r_td[c_DLY-1] ^ w_blk[ROUND]) : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctr_feistel_crypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctr_feistel_crypt
// Description : Scoreboard bench for ctr_feistel_crypt. An encrypt instance is
//               checked against a behavioural cipher model; a decrypt instance
//               fed from the encryptor must return the original plaintext.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctr_feistel_crypt;
    localparam int c_LAT = 31;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sbox_valid;
    logic [7:0]   sbox_out;
    logic         key_tvalid;
    logic [127:0] key;
    logic         tvalid;
    logic [255:0] text_in;
    logic [255:0] iv;
    logic         enc_valid;
    logic [255:0] enc_out;
    logic         dec_valid;
    logic [255:0] dec_out;
`ifdef CTR_FEISTEL_READY_EN
    logic         enc_ready;
    logic         dec_ready;
`endif

    always #5 clk = ~clk;

    ctr_feistel_crypt u_enc (
        .clk(clk), .reset_n(reset_n),
        .sbox_valid(sbox_valid), .sbox_out(sbox_out),
        .key_tvalid(key_tvalid), .key(key),
        .tvalid(tvalid), .text_in(text_in), .iv(iv),
`ifdef CTR_FEISTEL_READY_EN
        .ready(enc_ready),
`endif
        .valid(enc_valid), .text_out(enc_out)
    );

    ctr_feistel_crypt u_dec (
        .clk(clk), .reset_n(reset_n),
        .sbox_valid(sbox_valid), .sbox_out(sbox_out),
        .key_tvalid(key_tvalid), .key(key),
        .tvalid(enc_valid), .text_in(enc_out), .iv(iv),
`ifdef CTR_FEISTEL_READY_EN
        .ready(dec_ready),
`endif
        .valid(dec_valid), .text_out(dec_out)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [7:0]   m_sbox [256];
    logic [127:0] m_key  [5];
    int           m_sb_cnt;
    int           m_k_cnt;
    logic [255:0] m_ctr;

    typedef struct {
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t enc_q[$];
    exp_t dec_q[$];
    exp_t mon_e;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit m_ready();
        return (m_sb_cnt == 256) && (m_k_cnt == 5);
    endfunction

    function automatic logic [127:0] rotl(input logic [127:0] v, input int n);
        return (v << n) | (v >> (128 - n));
    endfunction

    // Keystream for counter block x: five Feistel rounds, no final swap.
    function automatic logic [255:0] keystream(input logic [255:0] x);
        logic [127:0] l, r, t, u, f, nl;
        l = x[255:128];
        r = x[127:0];
        for (int i = 0; i < 5; i++) begin
            t = r ^ m_key[i];
            for (int j = 0; j < 16; j++) u[8*j +: 8] = m_sbox[t[8*j +: 8]];
            f  = u ^ rotl(u, 8) ^ rotl(u, 32);
            nl = r;
            r  = l ^ f;
            l  = nl;
        end
        return {l, r};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: pops and compares whenever a DUT presents an output
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_on) begin
            while (enc_q.size() > 0 && enc_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL enc_missing: no output seen, required block at cycle %0d", enc_q[0].cyc);
                enc_q.delete(0);
            end
            checks++;
            if (enc_valid === 1'b1) begin
                if (enc_q.size() == 0) begin
                    errors++;
                    $display("FAIL enc_unexpected: valid=1 text_out=%h at cycle %0d, required valid=0", enc_out, cyc);
                end else begin
                    mon_e = enc_q.pop_front();
                    if (enc_out !== mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL enc_block: got %h at cycle %0d, required %h at cycle %0d", enc_out, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end else if (enc_valid !== 1'b0 || enc_out !== '0) begin
                errors++;
                $display("FAIL enc_idle: valid=%b text_out=%h, required valid=0 text_out=0", enc_valid, enc_out);
            end

            while (dec_q.size() > 0 && dec_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL dec_missing: no output seen, required block at cycle %0d", dec_q[0].cyc);
                dec_q.delete(0);
            end
            checks++;
            if (dec_valid === 1'b1) begin
                if (dec_q.size() == 0) begin
                    errors++;
                    $display("FAIL dec_unexpected: valid=1 text_out=%h at cycle %0d, required valid=0", dec_out, cyc);
                end else begin
                    mon_e = dec_q.pop_front();
                    if (dec_out !== mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL dec_roundtrip: got %h at cycle %0d, required %h at cycle %0d", dec_out, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end else if (dec_valid !== 1'b0 || dec_out !== '0) begin
                errors++;
                $display("FAIL dec_idle: valid=%b text_out=%h, required valid=0 text_out=0", dec_valid, dec_out);
            end
`ifdef CTR_FEISTEL_READY_EN
            checks++;
            if (enc_ready !== m_ready()) begin
                errors++;
                $display("FAIL ready: got %b at cycle %0d, required %b", enc_ready, cyc, m_ready());
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        enc_q.delete();
        dec_q.delete();
        m_sb_cnt = 0;
        m_k_cnt  = 0;
        m_ctr    = '0;
        checks++;
        if (enc_valid !== 1'b0 || enc_out !== '0 || dec_valid !== 1'b0 || dec_out !== '0) begin
            errors++;
            $display("FAIL reset_state: enc valid=%b out=%h dec valid=%b, required all zero", enc_valid, enc_out, dec_valid);
        end
    endtask

    // Loads 256 S-box entries plus 3 surplus beats, 5 keys plus 2 surplus.
    task automatic load_tables(input bit identity);
        logic [7:0] tbl [256];
        logic [7:0] tmp;
        int         j;
        for (int i = 0; i < 256; i++) tbl[i] = i[7:0];
        if (!identity) begin
            for (int i = 255; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = tbl[i]; tbl[i] = tbl[j]; tbl[j] = tmp;
            end
        end
        for (int i = 0; i < 259; i++) begin
            sbox_valid = 1'b1;
            sbox_out   = (i < 256) ? tbl[i] : 8'($urandom);
            if (m_sb_cnt < 256) m_sbox[m_sb_cnt] = sbox_out;
            tick();
            sbox_valid = 1'b0;
            if (m_sb_cnt < 256) m_sb_cnt++;
            if ($urandom_range(0, 7) == 0) tick();
        end
        for (int i = 0; i < 7; i++) begin
            key_tvalid = 1'b1;
            key        = (identity && i < 5) ? 128'd0 : rand256()[127:0];
            if (m_k_cnt < 5) m_key[m_k_cnt] = key;
            tick();
            key_tvalid = 1'b0;
            if (m_k_cnt < 5) m_k_cnt++;
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic send(input logic [255:0] d);
        exp_t e;
        tvalid  = 1'b1;
        text_in = d;
        if (m_ready()) begin
            e.data = d ^ keystream(iv + m_ctr);
            e.cyc  = cyc + 1 + c_LAT;
            enc_q.push_back(e);
            e.data = d;
            e.cyc  = cyc + 2 + 2 * c_LAT;
            dec_q.push_back(e);
            m_ctr = m_ctr + 256'd1;
        end
        tick();
        tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((enc_q.size() != 0 || dec_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (enc_q.size() != 0 || dec_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d enc and %0d dec blocks outstanding, required 0", enc_q.size(), dec_q.size());
        end
        repeat (3) tick();
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        reset_n    = 1'b1;
        sbox_valid = 1'b0;
        sbox_out   = '0;
        key_tvalid = 1'b0;
        key        = '0;
        tvalid     = 1'b0;
        text_in    = '0;
        iv         = '0;
        m_sb_cnt   = 0;
        m_k_cnt    = 0;
        m_ctr      = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        mon_on = 1'b1;

        // Blocks offered before the tables are loaded are dropped.
        repeat (3) send(rand256());
        tick();
        send(rand256());

        // Identity S-box, zero keys, iv=0: keystream is zero.
        load_tables(1'b1);
        send({32{8'hA5}});
        drain();

        // iv all-ones: second counter block wraps to zero.
        apply_reset();
        load_tables(1'b1);
        iv = '1;
        send(rand256());
        send(rand256());
        drain();

        // Random permutation S-box and keys, 10 back-to-back blocks.
        apply_reset();
        load_tables(1'b0);
        iv = 256'h3fa8b74c_9d2e1f60_5a7b3c81_e4d2f097_0b6c8a3d_71e95f24_8c3a0d6b_c6715aae;
        for (int i = 0; i < 10; i++) send(rand256());
        drain();

        // Random iv, blocks with random gaps.
        iv = rand256();
        for (int i = 0; i < 12; i++) begin
            send(rand256());
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        // Reset with blocks in flight, then reload and restart from ctr=0.
        for (int i = 0; i < 5; i++) send(rand256());
        repeat (3) tick();
        apply_reset();
        send(rand256());
        send(rand256());
        repeat (40) tick();
        load_tables(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(rand256());
            if ($urandom_range(0, 1) == 0) tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
